// File: rtl/fifo_ctrl_pkg.sv
// Shared types for the fifo_controller: data word, traffic-driver states.
package fifo_ctrl_pkg;

   localparam int DATA_W = 32;

   typedef logic [DATA_W-1:0] data_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_RECV,
      S_DONE_RSV
   } drv_state_t;

endpackage

// File: rtl/decoupled_vr_if.sv
// Decoupled valid/ready link: master drives valid/data, slave drives ready.
interface decoupled_vr_if;
   import fifo_ctrl_pkg::*;

   logic  valid;
   logic  ready;
   data_t data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/acc_traffic_driver.sv
// Bring-up traffic driver: sends N pattern beats to an accelerator, then sinks M results,
// reporting counts, XOR checksum, last result and a sticky timeout flag.
module acc_traffic_driver
   import fifo_ctrl_pkg::*;
#(
   parameter int    acc_index = 0,
   parameter data_t DATA_STEP = data_t'(1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [15:0]           serialization_ratio,
   input  logic [15:0]           deserialization_ratio,
   input  logic [15:0]           timeout_cycles,
   input  data_t                 seed,
   decoupled_vr_if.master        producer_data,
   decoupled_vr_if.slave         consumer_data,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout_err,
   output logic [15:0]           sent_cnt,
   output logic [15:0]           recv_cnt,
   output data_t                 checksum,
   output data_t                 last_rx,
   output logic [7:0]            status_acc_index
);

   drv_state_t  state_reg, state_next;
   logic [15:0] n_reg, n_next;
   logic [15:0] m_reg, m_next;
   logic [15:0] idle_reg, idle_next;
   data_t       pattern_reg, pattern_next;
   logic [15:0] sent_next, recv_next;
   data_t       checksum_next, last_next;
   logic        timeout_next, done_next, busy_next;

   // Link strobes decode straight from state so the first beat appears one cycle after start.
   assign producer_data.valid = (state_reg == S_SEND);
   assign producer_data.data  = pattern_reg;
   assign consumer_data.ready = (state_reg == S_RECV);
   assign status_acc_index    = 8'(acc_index);

   always_comb begin
      state_next    = state_reg;
      n_next        = n_reg;
      m_next        = m_reg;
      idle_next     = idle_reg;
      pattern_next  = pattern_reg;
      sent_next     = sent_cnt;
      recv_next     = recv_cnt;
      checksum_next = checksum;
      last_next     = last_rx;
      timeout_next  = timeout_err;
      done_next     = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (start) begin
               n_next        = serialization_ratio;
               m_next        = deserialization_ratio;
               pattern_next  = seed;
               sent_next     = '0;
               recv_next     = '0;
               checksum_next = '0;
               last_next     = '0;
               timeout_next  = 1'b0;
               idle_next     = '0;
               if (serialization_ratio != 16'd0)        state_next = S_SEND;
               else if (deserialization_ratio != 16'd0) state_next = S_RECV;
               else                                     done_next  = 1'b1;
            end
         end
         S_SEND: begin
            if (producer_data.ready) begin
               sent_next    = sent_cnt + 16'd1;
               pattern_next = pattern_reg + DATA_STEP;
               if (sent_next == n_reg) begin
                  if (m_reg != 16'd0) begin
                     state_next = S_RECV;
                  end else begin
                     state_next = S_IDLE;
                     done_next  = 1'b1;
                  end
               end
            end
         end
         S_RECV: begin
            if (consumer_data.valid) begin
               recv_next     = recv_cnt + 16'd1;
               checksum_next = checksum ^ consumer_data.data;
               last_next     = consumer_data.data;
               idle_next     = '0;
               if (recv_next == m_reg) begin
                  state_next = S_IDLE;
                  done_next  = 1'b1;
               end
            end else begin
               idle_next = idle_reg + 16'd1;
               if (timeout_cycles != 16'd0 && idle_next == timeout_cycles) begin
                  timeout_next = 1'b1;
                  state_next   = S_IDLE;
                  done_next    = 1'b1;
               end
            end
         end
         default: state_next = S_IDLE;
      endcase

      busy_next = (state_next == S_SEND) || (state_next == S_RECV);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= S_IDLE;
         n_reg       <= '0;
         m_reg       <= '0;
         idle_reg    <= '0;
         pattern_reg <= '0;
         sent_cnt    <= '0;
         recv_cnt    <= '0;
         checksum    <= '0;
         last_rx     <= '0;
         timeout_err <= 1'b0;
         done        <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state_reg   <= state_next;
         n_reg       <= n_next;
         m_reg       <= m_next;
         idle_reg    <= idle_next;
         pattern_reg <= pattern_next;
         sent_cnt    <= sent_next;
         recv_cnt    <= recv_next;
         checksum    <= checksum_next;
         last_rx     <= last_next;
         timeout_err <= timeout_next;
         done        <= done_next;
         busy        <= busy_next;
      end
   end

endmodule

// File: tb/tb_acc_traffic_driver.sv
// Directed bench for acc_traffic_driver; the bench plays the accelerator on both links.
module tb_acc_traffic_driver;
   import fifo_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] serialization_ratio = '0;
   logic [15:0] deserialization_ratio = '0;
   logic [15:0] timeout_cycles = '0;
   data_t       seed = '0;
   logic        busy, done, timeout_err;
   logic [15:0] sent_cnt, recv_cnt;
   data_t       checksum, last_rx;
   logic [7:0]  status_acc_index;

   int tests_run = 0;
   int tests_failed = 0;

   decoupled_vr_if p_if ();
   decoupled_vr_if c_if ();

   acc_traffic_driver #(.acc_index(3)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .start                 (start),
      .serialization_ratio   (serialization_ratio),
      .deserialization_ratio (deserialization_ratio),
      .timeout_cycles        (timeout_cycles),
      .seed                  (seed),
      .producer_data         (p_if.master),
      .consumer_data         (c_if.slave),
      .busy                  (busy),
      .done                  (done),
      .timeout_err           (timeout_err),
      .sent_cnt              (sent_cnt),
      .recv_cnt              (recv_cnt),
      .checksum              (checksum),
      .last_rx               (last_rx),
      .status_acc_index      (status_acc_index)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic launch(input logic [15:0] n, input logic [15:0] m, input data_t s);
      serialization_ratio   = n;
      deserialization_ratio = m;
      seed                  = s;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      automatic data_t rx_vals [4] = '{32'h1, 32'h2, 32'h4, 32'h8};
      automatic int    waited;

      p_if.ready = 1'b0;
      c_if.valid = 1'b0;
      c_if.data  = '0;

      // Reset state
      #2;
      check("rst_valid", 32'(p_if.valid), 32'd0);
      check("rst_ready", 32'(c_if.ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sent", 32'(sent_cnt), 32'd0);
      check("acc_index", 32'(status_acc_index), 32'd3);
      step();
      rst = 1'b0;
      step();

      // Test 1: N=4, M=4, everything always ready/valid
      p_if.ready = 1'b1;
      launch(16'd4, 16'd4, 32'h10);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t1_valid%0d", i), 32'(p_if.valid), 32'd1);
         check($sformatf("t1_data%0d", i), p_if.data, 32'h10 + 32'(i));
         step();
      end
      check("t1_sent", 32'(sent_cnt), 32'd4);
      check("t1_valid_off", 32'(p_if.valid), 32'd0);
      check("t1_ready_on", 32'(c_if.ready), 32'd1);
      c_if.valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         c_if.data = rx_vals[i];
         check($sformatf("t1_nodone%0d", i), 32'(done), 32'd0);
         step();
      end
      c_if.valid = 1'b0;
      check("t1_done", 32'(done), 32'd1);
      check("t1_busy", 32'(busy), 32'd0);
      check("t1_recv", 32'(recv_cnt), 32'd4);
      check("t1_checksum", checksum, 32'hF);
      check("t1_last", last_rx, 32'h8);
      step();
      check("t1_done_pulse", 32'(done), 32'd0);

      // Test 2: N=3, M=0, back-pressure on beat 2
      launch(16'd3, 16'd0, 32'h10);
      check("t2_data0", p_if.data, 32'h10);
      step();
      p_if.ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t2_hold_valid%0d", i), 32'(p_if.valid), 32'd1);
         check($sformatf("t2_hold_data%0d", i), p_if.data, 32'h11);
         step();
      end
      check("t2_sent_stall", 32'(sent_cnt), 32'd1);
      p_if.ready = 1'b1;
      step();
      check("t2_data2", p_if.data, 32'h12);
      step();
      check("t2_sent", 32'(sent_cnt), 32'd3);
      check("t2_done", 32'(done), 32'd1);
      check("t2_busy", 32'(busy), 32'd0);
      step();

      // Test 3: N=0, M=2
      launch(16'd0, 16'd2, 32'h99);
      check("t3_valid", 32'(p_if.valid), 32'd0);
      check("t3_ready", 32'(c_if.ready), 32'd1);
      check("t3_busy", 32'(busy), 32'd1);
      c_if.valid = 1'b1;
      c_if.data  = 32'hA;
      step();
      c_if.data  = 32'h5;
      step();
      c_if.valid = 1'b0;
      check("t3_done", 32'(done), 32'd1);
      check("t3_recv", 32'(recv_cnt), 32'd2);
      check("t3_sent", 32'(sent_cnt), 32'd0);
      check("t3_checksum", checksum, 32'hF);
      check("t3_last", last_rx, 32'h5);
      step();

      // Test 4: N=1, M=2, timeout 8, only one result returned
      timeout_cycles = 16'd8;
      launch(16'd1, 16'd2, 32'h20);
      step();
      c_if.valid = 1'b1;
      c_if.data  = 32'h33;
      step();
      c_if.valid = 1'b0;
      waited = 0;
      while (done !== 1'b1 && waited < 20) begin
         step();
         waited++;
      end
      check("t4_timeout_delay", 32'(waited), 32'd8);
      check("t4_timeout_err", 32'(timeout_err), 32'd1);
      check("t4_recv", 32'(recv_cnt), 32'd1);
      check("t4_busy", 32'(busy), 32'd0);
      step();
      check("t4_sticky", 32'(timeout_err), 32'd1);
      timeout_cycles = 16'd0;

      // Test 6: N=M=0 clears timeout_err and pulses done without busy
      launch(16'd0, 16'd0, 32'h0);
      check("t6_done", 32'(done), 32'd1);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_timeout_clr", 32'(timeout_err), 32'd0);
      step();
      check("t6_done_pulse", 32'(done), 32'd0);
      check("t6_busy_after", 32'(busy), 32'd0);

      // Test 5: start while busy ignored, then async reset mid-send
      p_if.ready = 1'b0;
      launch(16'd5, 16'd1, 32'h30);
      launch(16'd2, 16'd0, 32'h77);
      check("t5_ignore_data", p_if.data, 32'h30);
      check("t5_ignore_busy", 32'(busy), 32'd1);
      p_if.ready = 1'b1;
      step();
      step();
      check("t5_sent_mid", 32'(sent_cnt), 32'd2);
      rst = 1'b1;
      #1;
      check("t5_rst_valid", 32'(p_if.valid), 32'd0);
      check("t5_rst_sent", 32'(sent_cnt), 32'd0);
      check("t5_rst_busy", 32'(busy), 32'd0);
      check("t5_rst_done", 32'(done), 32'd0);
      step();
      rst = 1'b0;
      step();
      launch(16'd1, 16'd1, 32'h40);
      check("t5_fresh_data", p_if.data, 32'h40);
      step();
      c_if.valid = 1'b1;
      c_if.data  = 32'h55;
      step();
      c_if.valid = 1'b0;
      check("t5_fresh_done", 32'(done), 32'd1);
      check("t5_fresh_sent", 32'(sent_cnt), 32'd1);
      check("t5_fresh_recv", 32'(recv_cnt), 32'd1);
      check("t5_fresh_chk", checksum, 32'h55);
      step();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
